// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single byte-addressed,
// big-endian data memory. Port A is the CPU load/store stage; port B is the
// program loader / debug port. Each access runs IDLE -> ACCESS -> RESP.
// During ACCESS the memory strobes are high for one cycle. During RESP the
// owner sees a one-cycle ack.
// Optional build macro: DMEM_ARB_FIXED_PRIO_EN. When it is defined, port A
// always wins ties. By default, ties are resolved round-robin.
module dmem_arbiter #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    // port A (CPU)
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic [31:0] a_rdata,
    output logic        a_ack,
    output logic        a_err,
    // port B (loader / debug)
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic [31:0] b_rdata,
    output logic        b_ack,
    output logic        b_err,
    // memory side
    output logic [31:0] dm_address,
    output logic [31:0] dm_wdata,
    output logic        dm_write,
    output logic        dm_read,
    input  logic [31:0] dm_rdata,
    output logic        busy
);

    // Highest legal word address. Any address above this, or any address
    // that is not word aligned, is rejected.
    localparam logic [31:0] LAST_WORD = 32'(DEPTH - 4);

    // Owner encoding
    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    // latched command
    logic        r_owner;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err_l;
    logic        r_rr_last;

    // registered outputs
    logic        r_dm_write;
    logic        r_dm_read;
    logic [31:0] r_a_rdata;
    logic        r_a_ack;
    logic        r_a_err;
    logic [31:0] r_b_rdata;
    logic        r_b_ack;
    logic        r_b_err;
    logic        r_busy;

    // grant decode
    logic        w_grant;
    logic        w_owner;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_sel_err;

    // Address check: the address must be word aligned and must lie inside the memory.
    function automatic logic addr_bad(input logic [31:0] addr);
        addr_bad = (addr[1:0] != 2'b00) | (addr > LAST_WORD);
    endfunction

    // Next state, winner selection and the mux for the selected command
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_owner      = OWN_A;
        case (r_state)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    w_next_state = ST_ACCESS;
                    w_grant      = 1'b1;
                    if (a_req && b_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                        w_owner = OWN_A;
`else
                        w_owner = (r_rr_last == OWN_A) ? OWN_B : OWN_A;
`endif
                    end else if (a_req) begin
                        w_owner = OWN_A;
                    end else begin
                        w_owner = OWN_B;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACCESS: w_next_state = ST_RESP;
            ST_RESP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase

        if (w_owner == OWN_B) begin
            w_sel_we    = b_we;
            w_sel_addr  = b_addr;
            w_sel_wdata = b_wdata;
        end else begin
            w_sel_we    = a_we;
            w_sel_addr  = a_addr;
            w_sel_wdata = a_wdata;
        end
        w_sel_err = addr_bad(w_sel_addr);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Command latch, memory strobes and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner    <= OWN_A;
            r_we       <= 1'b0;
            r_addr     <= 32'h0000_0000;
            r_wdata    <= 32'h0000_0000;
            r_err_l    <= 1'b0;
            r_rr_last  <= OWN_B;
            r_dm_write <= 1'b0;
            r_dm_read  <= 1'b0;
            r_a_rdata  <= 32'h0000_0000;
            r_a_ack    <= 1'b0;
            r_a_err    <= 1'b0;
            r_b_rdata  <= 32'h0000_0000;
            r_b_ack    <= 1'b0;
            r_b_err    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            // Strobes and acks are single-cycle pulses.
            r_dm_write <= 1'b0;
            r_dm_read  <= 1'b0;
            r_a_ack    <= 1'b0;
            r_b_ack    <= 1'b0;
            r_busy     <= (w_next_state != ST_IDLE);

            if (w_grant) begin
                // Latch the command. The strobes for the ACCESS cycle are
                // computed here, so the ACCESS cycle depends only on flops.
                r_owner    <= w_owner;
                r_we       <= w_sel_we;
                r_addr     <= w_sel_addr;
                r_wdata    <= w_sel_wdata;
                r_err_l    <= w_sel_err;
                r_rr_last  <= w_owner;
                r_dm_write <= w_sel_we & ~w_sel_err;
                r_dm_read  <= ~w_sel_we & ~w_sel_err;
            end else begin
                r_owner    <= r_owner;
            end

            if (r_state == ST_ACCESS) begin
                // Memory read data is combinational. Capture it at the
                // posedge that closes the ACCESS cycle.
                if (r_owner == OWN_B) begin
                    r_b_rdata <= (~r_we & ~r_err_l) ? dm_rdata : 32'h0000_0000;
                    r_b_err   <= r_err_l;
                    r_b_ack   <= 1'b1;
                end else begin
                    r_a_rdata <= (~r_we & ~r_err_l) ? dm_rdata : 32'h0000_0000;
                    r_a_err   <= r_err_l;
                    r_a_ack   <= 1'b1;
                end
            end else begin
                r_a_rdata <= r_a_rdata;
            end
        end
    end

    assign dm_address = r_addr;
    assign dm_wdata   = r_wdata;
    assign dm_write   = r_dm_write;
    assign dm_read    = r_dm_read;
    assign a_rdata    = r_a_rdata;
    assign a_ack      = r_a_ack;
    assign a_err      = r_a_err;
    assign b_rdata    = r_b_rdata;
    assign b_ack      = r_b_ack;
    assign b_err      = r_b_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter. The bench contains a big-endian byte
// memory model. That model commits writes on the negedge and returns read
// data combinationally.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [31:0] a_rdata, b_rdata;
    logic        a_ack, a_err, b_ack, b_err;
    logic [31:0] dm_address, dm_wdata, dm_rdata;
    logic        dm_write, dm_read, busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:255];

    dmem_arbiter #(.DEPTH(256)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ack(a_ack), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ack(b_ack), .b_err(b_err),
        .dm_address(dm_address), .dm_wdata(dm_wdata),
        .dm_write(dm_write), .dm_read(dm_read), .dm_rdata(dm_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Big-endian memory model: write on negedge, combinational read
    always @(negedge clk) begin
        if (dm_write) begin
            mem[(dm_address[7:0] + 8'd0)] <= dm_wdata[31:24];
            mem[(dm_address[7:0] + 8'd1)] <= dm_wdata[23:16];
            mem[(dm_address[7:0] + 8'd2)] <= dm_wdata[15:8];
            mem[(dm_address[7:0] + 8'd3)] <= dm_wdata[7:0];
        end
    end

    assign dm_rdata = {mem[dm_address[7:0] + 8'd0], mem[dm_address[7:0] + 8'd1],
                       mem[dm_address[7:0] + 8'd2], mem[dm_address[7:0] + 8'd3]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access on a single port. The latency is fixed:
    // grant edge -> ACCESS, next edge -> RESP.
    task automatic access(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err);
        if (port) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
        end
        tick();   // ACCESS
        check("acc_busy",  {31'd0, busy},     32'd1);
        check("acc_write", {31'd0, dm_write}, {31'd0, we & ~exp_err});
        check("acc_read",  {31'd0, dm_read},  {31'd0, ~we & ~exp_err});
        if (!exp_err) check("acc_addr", dm_address, addr);
        tick();   // RESP
        check("rsp_ack",   {31'd0, port ? b_ack : a_ack}, 32'd1);
        check("rsp_other", {31'd0, port ? a_ack : b_ack}, 32'd0);
        check("rsp_err",   {31'd0, port ? b_err : a_err}, {31'd0, exp_err});
        check("rsp_rdata", port ? b_rdata : a_rdata, exp_rdata);
        check("rsp_strb",  {30'd0, dm_write, dm_read}, 32'd0);
        a_req = 1'b0; b_req = 1'b0;
        tick();   // back in IDLE
        check("idle_ack",  {30'd0, a_ack, b_ack}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic order [0:3];
        int   n_ack;
        int   budget;
        for (int i = 0; i < 256; i++) mem[i] = i[7:0];
        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
        do_reset();

        // reset state
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_acks",  {28'd0, a_ack, b_ack, a_err, b_err}, 32'd0);
        check("rst_strb",  {30'd0, dm_write, dm_read}, 32'd0);
        check("rst_addr",  dm_address, 32'h0);
        check("rst_wdata", dm_wdata, 32'h0);
        check("rst_rdata", a_rdata | b_rdata, 32'h0);

        // basic write/read on port A
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        check("mem_0x10", {mem[16], mem[17], mem[18], mem[19]}, 32'hDEADBEEF);
        access(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // contention: both ports read continuously
        do_reset();
        a_we = 1'b0; a_addr = 32'h10;
        b_we = 1'b0; b_addr = 32'h14;
        a_req = 1'b1; b_req = 1'b1;
        n_ack = 0; budget = 0;
        while (n_ack < 4 && budget < 30) begin
            tick();
            budget++;
            if (a_ack && b_ack) check("ack_overlap", 32'd1, 32'd0);
            if (a_ack) begin
                order[n_ack] = 1'b0;
                n_ack++;
                check("cont_a_rdata", a_rdata, 32'hDEADBEEF);
            end else if (b_ack) begin
                order[n_ack] = 1'b1;
                n_ack++;
                check("cont_b_rdata", b_rdata, 32'h14151617);
            end
        end
        check("cont_count", n_ack, 32'd4);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        check("order0", {31'd0, order[0]}, 32'd0);
        check("order1", {31'd0, order[1]}, 32'd0);
        check("order2", {31'd0, order[2]}, 32'd0);
        check("order3", {31'd0, order[3]}, 32'd0);
`else
        check("order0", {31'd0, order[0]}, 32'd0);
        check("order1", {31'd0, order[1]}, 32'd1);
        check("order2", {31'd0, order[2]}, 32'd0);
        check("order3", {31'd0, order[3]}, 32'd1);
`endif
        // A drops out; the pending B request must then be served
        a_req = 1'b0;
        budget = 0;
        while (!b_ack && budget < 10) begin
            tick();
            budget++;
            if (a_ack) check("b_after_a_ack", 32'd1, 32'd0);
        end
        check("b_served", {31'd0, b_ack}, 32'd1);
        b_req = 1'b0;
        tick();
        tick();

        // B reads: one good read, then a misaligned address and an out-of-range address
        access(1'b1, 1'b0, 32'h14, 32'h0, 32'h14151617, 1'b0);
        access(1'b1, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1);
        access(1'b1, 1'b0, 32'hFD, 32'h0, 32'h0, 1'b1);
        access(1'b1, 1'b1, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1);

        // last legal word
        access(1'b0, 1'b1, 32'hFC, 32'h01020304, 32'h0, 1'b0);
        access(1'b0, 1'b0, 32'hFC, 32'h0, 32'h01020304, 1'b0);

        // reset in the cycle where the FSM would enter ACCESS: nothing happens
        b_req = 1'b1; b_we = 1'b1; b_addr = 32'h24; b_wdata = 32'hCAFEF00D;
        rst = 1'b1;
        tick();
        b_req = 1'b0; rst = 1'b0;
        check("rst_grant_busy",  {31'd0, busy}, 32'd0);
        check("rst_grant_write", {31'd0, dm_write}, 32'd0);
        tick();
        check("rst_grant_mem", {mem[36], mem[37], mem[38], mem[39]}, 32'h24252627);

        // reset during ACCESS of a B write: the write still commits, and no ack is issued
        b_req = 1'b1; b_we = 1'b1; b_addr = 32'h20; b_wdata = 32'h55AA55AA;
        tick();   // ACCESS
        check("rstacc_write", {31'd0, dm_write}, 32'd1);
        rst = 1'b1; b_req = 1'b0;
        tick();
        rst = 1'b0;
        check("rstacc_ack",  {31'd0, b_ack}, 32'd0);
        check("rstacc_busy", {31'd0, busy}, 32'd0);
        tick();
        check("rstacc_ack2", {31'd0, b_ack}, 32'd0);
        access(1'b0, 1'b0, 32'h20, 32'h0, 32'h55AA55AA, 1'b0);

        // the command changes after the grant; the latched values must be used
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h30; a_wdata = 32'h12345678;
        tick();   // ACCESS
        a_addr = 32'h40; a_wdata = 32'h0;
        #1;
        check("chg_addr",  dm_address, 32'h30);
        check("chg_wdata", dm_wdata, 32'h12345678);
        tick();   // RESP
        check("chg_ack", {31'd0, a_ack}, 32'd1);
        a_req = 1'b0;
        tick();
        access(1'b0, 1'b0, 32'h30, 32'h0, 32'h12345678, 1'b0);
        access(1'b0, 1'b0, 32'h40, 32'h0, 32'h40414243, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
